// File: rtl/mem_pkg.sv
// Shared types for the RISC-V data memory: funct3 size/sign codes, FSM states,
// word geometry and the funct3 legality helper.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTES  = WORD_W / 8;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store bus between the core LSU (master) and data_mem (slave).
//   req/we/funct3/addr/dataW : request from the LSU
//   ready                    : request accepted when req && ready
//   rvalid/dataR             : one-cycle load response
//   fault                    : one-cycle fault pulse for an accepted request
//   busy                     : post-reset clear sweep in progress
interface data_mem_if #(
    parameter int unsigned AW = 32
);
    import mem_pkg::*;

    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] dataW;
    logic              ready;
    logic              rvalid;
    logic [WORD_W-1:0] dataR;
    logic              fault;
    logic              busy;

    modport master (
        output req, we, funct3, addr, dataW,
        input  ready, rvalid, dataR, fault, busy
    );

    modport slave (
        input  req, we, funct3, addr, dataW,
        output ready, rvalid, dataR, fault, busy
    );

endinterface

// File: rtl/load_extend.sv
// Combinational load formatter: selects the addressed byte/half/word of a
// memory word, shifts it to bit 0 and sign- or zero-extends it.
//   word_i   : raw 32-bit array word
//   off_i    : byte offset addr[1:0]
//   funct3_i : load size/sign code
//   ext_c    : extended result (0 for an unknown code)
module load_extend
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [WORD_W-1:0] ext_c
);

    logic [WORD_W-1:0] sh_c;

    // Right-align the addressed lane, then extend by size.
    always_comb begin
        sh_c  = word_i >> {off_i, 3'b000};
        ext_c = '0;
        case (funct3_i)
            F3_B:    ext_c = {{24{sh_c[7]}}, sh_c[7:0]};
            F3_H:    ext_c = {{16{sh_c[15]}}, sh_c[15:0]};
            F3_W:    ext_c = sh_c;
            F3_BU:   ext_c = {24'h0, sh_c[7:0]};
            F3_HU:   ext_c = {16'h0, sh_c[15:0]};
            default: ext_c = '0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// RISC-V data memory: DEPTH x 32-bit array with byte/half/word loads and
// stores, lane strobes, load extension, alignment/legality/range faults and an
// optional post-reset zero sweep. Loads respond one cycle after acceptance.
//   clock, nreset : clock and asynchronous active-low reset
//   bus           : data_mem_if slave port (request, response, fault, busy)
module data_mem
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH          = 512,
    parameter int unsigned AW             = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic       clock,
    input  logic       nreset,
    data_mem_if.slave  bus
);

    localparam int unsigned IW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic              clr_we_c;

    logic              rvalid_q, rvalid_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] dataR_q, dataR_d;

    logic [AW-1:0]     addr_c;
    logic [IW-1:0]     idx_c;
    logic [1:0]        off_c;
    logic              ready_c;
    logic              accept_c;
    logic              rng_c;
    logic              mis_c;
    logic              fault_c;
    logic              store_c;
    logic              load_c;
    logic [BYTES-1:0]  strb_c;
    logic [WORD_W-1:0] wdata_c;
    logic [WORD_W-1:0] rd_word_c;
    logic [WORD_W-1:0] ext_c;

    logic [WORD_W-1:0] mem [DEPTH];

    // Request decode and fault checks.
    always_comb begin
        addr_c   = bus.addr;
        idx_c    = addr_c[IW+1:2];
        off_c    = addr_c[1:0];
        ready_c  = (state_q == RUN);
        accept_c = bus.req && ready_c;
        rng_c    = |(addr_c >> (IW + 2));
        case (bus.funct3[1:0])
            2'b01:   mis_c = off_c[0];
            2'b10:   mis_c = (off_c != 2'b00);
            default: mis_c = 1'b0;
        endcase
        fault_c  = !f3_legal(bus.funct3, bus.we) || mis_c || rng_c;
        store_c  = accept_c && bus.we && !fault_c;
        load_c   = accept_c && !bus.we;
    end

    // Lane strobes and store data replicated onto every lane.
    always_comb begin
        case (bus.funct3[1:0])
            2'b00: begin
                strb_c  = BYTES'(4'b0001 << off_c);
                wdata_c = {4{bus.dataW[7:0]}};
            end
            2'b01: begin
                strb_c  = BYTES'(4'b0011 << off_c);
                wdata_c = {2{bus.dataW[15:0]}};
            end
            default: begin
                strb_c  = '1;
                wdata_c = bus.dataW;
            end
        endcase
    end

    // Array write port: clear sweep has priority (requests are not accepted then).
    always_ff @(posedge clock) begin
        if (clr_we_c) begin
            mem[cnt_q] <= '0;
        end else if (store_c) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                if (strb_c[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

    assign rd_word_c = mem[idx_c];

    load_extend u_load_extend (
        .word_i   (rd_word_c),
        .off_i    (off_c),
        .funct3_i (bus.funct3),
        .ext_c    (ext_c)
    );

    // Next-state, sweep counter and response registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_c = 1'b0;
        rvalid_d = load_c;
        fault_d  = accept_c && fault_c;
        dataR_d  = dataR_q;
        case (state_q)
            CLEAR: begin
                clr_we_c = 1'b1;
                cnt_d    = cnt_q + IW'(1);
                if (cnt_q == IW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load_c) begin
                    dataR_d = fault_c ? '0 : ext_c;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            dataR_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            dataR_q  <= dataR_d;
        end
    end

    assign bus.ready  = ready_c;
    assign bus.busy   = !ready_c;
    assign bus.rvalid = rvalid_q;
    assign bus.fault  = fault_q;
    assign bus.dataR  = dataR_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: a DEPTH=16 instance with the
// clear sweep and a DEPTH=512 instance without it.
module tb_data_mem;
    import mem_pkg::*;

    logic clock;
    logic nreset;
    int   checks;
    int   errors;

    data_mem_if #(.AW(32)) bus_a ();
    data_mem_if #(.AW(32)) bus_b ();

    data_mem #(.DEPTH(16), .AW(32), .CLEAR_ON_RESET(1)) dut_a (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus_a.slave)
    );

    data_mem #(.DEPTH(512), .AW(32), .CLEAR_ON_RESET(0)) dut_b (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] exp;
        string       tag;
    } ld_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_a(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bus_a.req = 1'b1; bus_a.we = w; bus_a.funct3 = f; bus_a.addr = a; bus_a.dataW = d;
    endtask

    task automatic issue_b(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bus_b.req = 1'b1; bus_b.we = w; bus_b.funct3 = f; bus_b.addr = a; bus_b.dataW = d;
    endtask

    // Count cycles until A leaves the sweep; note any response seen meanwhile.
    task automatic wait_ready(output int n, output logic saw);
        n = 0;
        saw = 1'b0;
        while (bus_a.ready !== 1'b1 && n < 100) begin
            step();
            n++;
            if (bus_a.rvalid !== 1'b0) saw = 1'b1;
        end
    endtask

    ld_t  lds [10];
    int   n;
    logic saw;

    initial begin
        checks = 0;
        errors = 0;
        lds = '{
            '{F3_B,  32'h8, 32'h00000001, "lb8"},
            '{F3_B,  32'h9, 32'h0000007F, "lb9"},
            '{F3_B,  32'hA, 32'hFFFFFFFF, "lbA"},
            '{F3_B,  32'hB, 32'hFFFFFF80, "lbB"},
            '{F3_BU, 32'hB, 32'h00000080, "lbuB"},
            '{F3_H,  32'hA, 32'hFFFF80FF, "lhA"},
            '{F3_HU, 32'h8, 32'h00007F01, "lhu8"},
            '{F3_H,  32'h8, 32'h00007F01, "lh8"},
            '{F3_W,  32'h8, 32'h80FF7F01, "lw8"},
            '{F3_BU, 32'hA, 32'h000000FF, "lbuA"}
        };

        nreset = 1'b0;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.funct3 = 3'b010; bus_a.addr = '0; bus_a.dataW = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.funct3 = 3'b010; bus_b.addr = '0; bus_b.dataW = '0;
        repeat (3) step();

        chk("rst_ready_a",  32'(bus_a.ready),  32'd0);
        chk("rst_busy_a",   32'(bus_a.busy),   32'd1);
        chk("rst_rvalid_a", 32'(bus_a.rvalid), 32'd0);
        chk("rst_fault_a",  32'(bus_a.fault),  32'd0);
        chk("rst_dataR_a",  bus_a.dataR,       32'h0);
        chk("rst_ready_b",  32'(bus_b.ready),  32'd1);
        chk("rst_busy_b",   32'(bus_b.busy),   32'd0);

        // Load held during the sweep must be ignored.
        issue_a(1'b0, F3_W, 32'h0, 32'h0);
        nreset = 1'b1;
        wait_ready(n, saw);
        chk("sweep_len", 32'(n), 32'd16);
        chk("sweep_noresp", 32'(saw), 32'd0);
        chk("sweep_busy", 32'(bus_a.busy), 32'd0);

        issue_a(1'b0, F3_W, 32'h3C, 32'h0);
        step();
        chk("lw3c_rvalid", 32'(bus_a.rvalid), 32'd1);
        chk("lw3c_data",   bus_a.dataR,       32'h0);
        chk("lw3c_fault",  32'(bus_a.fault),  32'd0);

        // Store then back-to-back loads, one response per cycle.
        issue_a(1'b1, F3_W, 32'h8, 32'h80FF7F01);
        step();
        chk("sw8_rvalid", 32'(bus_a.rvalid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            issue_a(1'b0, lds[i].f, lds[i].a, 32'h0);
            step();
            chk({lds[i].tag, "_rvalid"}, 32'(bus_a.rvalid), 32'd1);
            chk({lds[i].tag, "_data"},   bus_a.dataR,       lds[i].exp);
        end
        bus_a.req = 1'b0;
        step();
        chk("idle_rvalid", 32'(bus_a.rvalid), 32'd0);
        chk("idle_hold",   bus_a.dataR,       32'h000000FF);

        // Partial stores; upper dataW bits must not leak.
        issue_a(1'b1, F3_W, 32'h4, 32'h11223344); step();
        issue_a(1'b1, F3_B, 32'h5, 32'hFFFFFFAA); step();
        issue_a(1'b0, F3_W, 32'h4, 32'h0);        step();
        chk("sb5_lw4", bus_a.dataR, 32'h1122AA44);
        issue_a(1'b1, F3_H, 32'h6, 32'h1234BEEF); step();
        issue_a(1'b0, F3_W, 32'h4, 32'h0);        step();
        chk("sh6_lw4", bus_a.dataR, 32'hBEEFAA44);
        issue_a(1'b0, F3_HU, 32'h6, 32'h0);       step();
        chk("lhu6", bus_a.dataR, 32'h0000BEEF);

        // Faults.
        issue_a(1'b0, F3_H, 32'h3, 32'h0); step();
        chk("lh3_fault",  32'(bus_a.fault),  32'd1);
        chk("lh3_rvalid", 32'(bus_a.rvalid), 32'd1);
        chk("lh3_data",   bus_a.dataR,       32'h0);
        bus_a.req = 1'b0; step();
        chk("fault_pulse", 32'(bus_a.fault), 32'd0);
        chk("rvalid_pulse", 32'(bus_a.rvalid), 32'd0);

        issue_a(1'b1, F3_W, 32'h2, 32'h55555555); step();
        chk("sw2_fault",  32'(bus_a.fault),  32'd1);
        chk("sw2_rvalid", 32'(bus_a.rvalid), 32'd0);
        issue_a(1'b0, F3_W, 32'h0, 32'h0); step();
        chk("sw2_unchanged", bus_a.dataR, 32'h0);
        chk("lw0_fault", 32'(bus_a.fault), 32'd0);

        issue_a(1'b0, 3'b011, 32'h0, 32'h0); step();
        chk("f3_011_fault",  32'(bus_a.fault),  32'd1);
        chk("f3_011_rvalid", 32'(bus_a.rvalid), 32'd1);
        issue_a(1'b1, F3_BU, 32'h4, 32'h0); step();
        chk("sbu_fault", 32'(bus_a.fault), 32'd1);
        issue_a(1'b0, F3_W, 32'h40, 32'h0); step();
        chk("rng_ld_fault", 32'(bus_a.fault), 32'd1);
        chk("rng_ld_data",  bus_a.dataR,      32'h0);
        issue_a(1'b1, F3_W, 32'h44, 32'h77777777); step();
        chk("rng_st_fault", 32'(bus_a.fault), 32'd1);
        issue_a(1'b0, F3_W, 32'h4, 32'h0); step();
        chk("word4_intact", bus_a.dataR, 32'hBEEFAA44);

        // Store immediately followed by load of the same word.
        issue_a(1'b1, F3_W, 32'h10, 32'hDEADBEEF); step();
        issue_a(1'b0, F3_W, 32'h10, 32'h0);        step();
        chk("raw_10", bus_a.dataR, 32'hDEADBEEF);
        bus_a.req = 1'b0;

        // DEPTH=512 range boundary.
        issue_b(1'b0, F3_W, 32'h1000, 32'h0); step();
        chk("b_1000_fault",  32'(bus_b.fault),  32'd1);
        chk("b_1000_rvalid", 32'(bus_b.rvalid), 32'd1);
        chk("b_1000_data",   bus_b.dataR,       32'h0);
        issue_b(1'b1, F3_W, 32'h7FC, 32'hCAFEF00D); step();
        chk("b_7fc_st_fault", 32'(bus_b.fault), 32'd0);
        issue_b(1'b1, F3_W, 32'h17FC, 32'h0BADF00D); step();
        chk("b_17fc_fault", 32'(bus_b.fault), 32'd1);
        issue_b(1'b0, F3_W, 32'h7FC, 32'h0); step();
        chk("b_7fc_data",  bus_b.dataR,      32'hCAFEF00D);
        chk("b_7fc_fault", 32'(bus_b.fault), 32'd0);
        bus_b.req = 1'b0;

        // Reset in the middle of the sweep restarts it.
        issue_a(1'b1, F3_W, 32'h3C, 32'h12345678); step();
        bus_a.req = 1'b0;
        nreset = 1'b0; step();
        nreset = 1'b1;
        repeat (7) step();
        chk("mid_busy", 32'(bus_a.busy), 32'd1);
        issue_a(1'b1, F3_W, 32'h3C, 32'h12345678);
        nreset = 1'b0;
        #1;
        chk("mid_rst_ready",  32'(bus_a.ready),  32'd0);
        chk("mid_rst_busy",   32'(bus_a.busy),   32'd1);
        chk("mid_rst_rvalid", 32'(bus_a.rvalid), 32'd0);
        chk("mid_rst_fault",  32'(bus_a.fault),  32'd0);
        chk("mid_rst_dataR",  bus_a.dataR,       32'h0);
        #1;
        nreset = 1'b1;
        wait_ready(n, saw);
        chk("resweep_len", 32'(n), 32'd16);
        chk("resweep_noresp", 32'(saw), 32'd0);
        issue_a(1'b0, F3_W, 32'h3C, 32'h0); step();
        chk("resweep_3c_rvalid", 32'(bus_a.rvalid), 32'd1);
        chk("resweep_3c_data",   bus_a.dataR,       32'h0);
        bus_a.req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
